// File: rtl/branch_predictor_dyn.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_dyn
// Brief    : Bimodal/gshare saturating-counter branch predictor with a
//            static sign-of-offset fallback for entries not yet trained.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_dyn #(
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int MODE      = 0,
    parameter int HIST_BITS = 4,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_imm,
    output logic             br_pred,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             ex_upd_en,
    input  logic [IDX_W-1:0] ex_upd_idx,
    input  logic             ex_taken,
    input  logic             ex_mispred,
    output logic [31:0]      br_cnt,
    output logic [31:0]      mispred_cnt
);

    localparam logic [CTR_BITS-1:0] c_weak_t  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] c_weak_nt = c_weak_t - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] c_ctr_max = '1;
    localparam logic [CTR_BITS-1:0] c_ctr_min = '0;

    logic [CTR_BITS-1:0] r_ctr [ENTRIES];
    logic [ENTRIES-1:0]  r_vld;
    logic [31:0]         r_br_cnt;
    logic [31:0]         r_mispred_cnt;

    logic [IDX_W-1:0]    w_pc_idx;
    logic [IDX_W-1:0]    w_hist;
    logic [IDX_W-1:0]    w_idx;
    logic [CTR_BITS-1:0] w_lookup_ctr;
    logic [CTR_BITS-1:0] w_old_ctr;
    logic [CTR_BITS-1:0] w_new_ctr;
    logic                w_unused;

    assign w_pc_idx = id_pc[IDX_W+1:2];

    // History only exists in gshare mode; it trains non-speculatively from EX.
    generate
        if (MODE == 1) begin : g_gshare
            logic [HIST_BITS-1:0] r_ghr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (ex_upd_en) begin
                    r_ghr <= HIST_BITS'({r_ghr, ex_taken});
                end
            end

            assign w_hist = rst ? '0 : IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_hist = '0;
        end
    endgenerate

    assign w_idx        = w_pc_idx ^ w_hist;
    assign w_lookup_ctr = r_ctr[w_idx];
    assign pred_idx     = w_idx;
    assign br_pred      = (!rst && r_vld[w_idx]) ? w_lookup_ctr[CTR_BITS-1] : id_imm[31];

    // First sighting seeds the entry at the weak state of the outcome.
    always_comb begin
        w_old_ctr = r_ctr[ex_upd_idx];
        w_new_ctr = w_old_ctr;
        if (!r_vld[ex_upd_idx]) begin
            w_new_ctr = ex_taken ? c_weak_t : c_weak_nt;
        end else if (ex_taken) begin
            if (w_old_ctr != c_ctr_max) w_new_ctr = w_old_ctr + CTR_BITS'(1);
        end else begin
            if (w_old_ctr != c_ctr_min) w_new_ctr = w_old_ctr - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_weak_nt;
            end
            r_vld         <= '0;
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (ex_upd_en) begin
            r_ctr[ex_upd_idx] <= w_new_ctr;
            r_vld[ex_upd_idx] <= 1'b1;
            if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
            if (ex_mispred && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;

    assign w_unused = ^{id_pc[31:IDX_W+2], id_pc[1:0], id_imm[30:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_dyn.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_dyn
// Brief    : Self-checking bench for branch_predictor_dyn (bimodal + gshare).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_dyn;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_pc, id_imm;
    logic        ex_upd_en, ex_taken, ex_mispred;
    logic [5:0]  ex_upd_idx;

    logic        pred0, pred1;
    logic [5:0]  idx0, idx1;
    logic [31:0] br0, mis0, br1, mis1;

    int errors = 0;
    int checks = 0;

    // Reference state: plain integer counters per entry, one set per instance.
    int      m_ctr [2][64];
    bit      m_vld [2][64];
    int      m_ghr;
    longint  m_br, m_mis;

    always #5 clk = ~clk;

    branch_predictor_dyn #(.ENTRIES(64), .CTR_BITS(2), .MODE(0), .HIST_BITS(4)) dut0 (
        .clk(clk), .rst(rst), .id_pc(id_pc), .id_imm(id_imm),
        .br_pred(pred0), .pred_idx(idx0),
        .ex_upd_en(ex_upd_en), .ex_upd_idx(ex_upd_idx), .ex_taken(ex_taken),
        .ex_mispred(ex_mispred), .br_cnt(br0), .mispred_cnt(mis0)
    );

    branch_predictor_dyn #(.ENTRIES(64), .CTR_BITS(2), .MODE(1), .HIST_BITS(4)) dut1 (
        .clk(clk), .rst(rst), .id_pc(id_pc), .id_imm(id_imm),
        .br_pred(pred1), .pred_idx(idx1),
        .ex_upd_en(ex_upd_en), .ex_upd_idx(ex_upd_idx), .ex_taken(ex_taken),
        .ex_mispred(ex_mispred), .br_cnt(br1), .mispred_cnt(mis1)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        en;
        logic [5:0]  uidx;
        logic        tk;
        logic        mp;
        logic        e_pred;
        logic [5:0]  e_idx;
        logic [31:0] e_br;
        logic [31:0] e_mis;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_idx(int inst, logic [31:0] pc, logic r);
        int base;
        base = int'((pc >> 2) & 32'h3f);
        if (inst == 1 && !r) base = base ^ m_ghr;
        return base;
    endfunction

    function automatic logic m_pred(int inst, logic [31:0] pc, logic [31:0] imm, logic r);
        int i;
        i = m_idx(inst, pc, r);
        if (!r && m_vld[inst][i]) return (m_ctr[inst][i] >= 2);
        return imm[31];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int e = 0; e < 64; e++) begin
                m_ctr[n][e] = 1;
                m_vld[n][e] = 1'b0;
            end
        end
        m_ghr = 0;
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (ex_upd_en) begin
            for (int n = 0; n < 2; n++) begin
                int e;
                e = int'(ex_upd_idx);
                if (!m_vld[n][e]) m_ctr[n][e] = ex_taken ? 2 : 1;
                else if (ex_taken) m_ctr[n][e] = (m_ctr[n][e] + 1 > 3) ? 3 : m_ctr[n][e] + 1;
                else m_ctr[n][e] = (m_ctr[n][e] - 1 < 0) ? 0 : m_ctr[n][e] - 1;
                m_vld[n][e] = 1'b1;
            end
            m_ghr = ((m_ghr * 2) + (ex_taken ? 1 : 0)) % 16;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (ex_mispred && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic r, input logic [31:0] pc, input logic [31:0] imm,
                          input logic en, input logic [5:0] uidx, input logic tk, input logic mp);
        rst = r; id_pc = pc; id_imm = imm;
        ex_upd_en = en; ex_upd_idx = uidx; ex_taken = tk; ex_mispred = mp;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_pred0"}, 32'(pred0), 32'(m_pred(0, id_pc, id_imm, rst)));
        chk({tag, "_idx0"},  32'(idx0),  32'(m_idx(0, id_pc, rst)));
        chk({tag, "_pred1"}, 32'(pred1), 32'(m_pred(1, id_pc, id_imm, rst)));
        chk({tag, "_idx1"},  32'(idx1),  32'(m_idx(1, id_pc, rst)));
        chk({tag, "_br"},    br1,        32'(m_br));
        chk({tag, "_mis"},   mis1,       32'(m_mis));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-derived bimodal sequence on entry 0x10; checks see pre-edge state.
        vecs[0]  = '{1'b0, 32'h40,  32'hFFFF_FFF0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h10, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b1, 1'b0, 1'b0, 6'h10, 32'd0, 32'd0};
        vecs[2]  = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b1, 1'b0, 1'b1, 6'h10, 32'd1, 32'd0};
        vecs[3]  = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b1, 1'b0, 1'b1, 6'h10, 32'd2, 32'd0};
        vecs[4]  = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b0, 1'b0, 1'b1, 6'h10, 32'd3, 32'd0};
        vecs[5]  = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b0, 1'b1, 1'b1, 6'h10, 32'd4, 32'd0};
        vecs[6]  = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b1, 1'b1, 1'b0, 6'h10, 32'd5, 32'd1};
        vecs[7]  = '{1'b0, 32'h40,  32'h8,         1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h10, 32'd6, 32'd2};
        vecs[8]  = '{1'b0, 32'h140, 32'h8,         1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h10, 32'd6, 32'd2};
        vecs[9]  = '{1'b1, 32'h40,  32'h8,         1'b1, 6'h10, 1'b1, 1'b1, 1'b0, 6'h10, 32'd6, 32'd2};
        vecs[10] = '{1'b0, 32'h40,  32'h8,         1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h10, 32'd0, 32'd0};
        vecs[11] = '{1'b0, 32'h40,  32'h8,         1'b1, 6'h10, 1'b0, 1'b0, 1'b0, 6'h10, 32'd0, 32'd0};
        vecs[12] = '{1'b0, 32'h40,  32'hFFFF_FFF0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h10, 32'd1, 32'd0};

        model_reset();
        set_in(1'b1, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
        tick();
        tick();

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].rst, vecs[i].pc, vecs[i].imm, vecs[i].en, vecs[i].uidx, vecs[i].tk, vecs[i].mp);
            @(negedge clk);
            chk($sformatf("vec%0d_pred", i), 32'(pred0), 32'(vecs[i].e_pred));
            chk($sformatf("vec%0d_idx", i),  32'(idx0),  32'(vecs[i].e_idx));
            chk($sformatf("vec%0d_br", i),   br0,        vecs[i].e_br);
            chk($sformatf("vec%0d_mis", i),  mis0,       vecs[i].e_mis);
            cmp_model($sformatf("vec%0d_mdl", i));
            tick();
        end

        // Gshare history: five updates ending T,T,N,T leave ghr = 4'b1101.
        set_in(1'b1, 32'h100, 32'h8, 1'b0, 6'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h100, 32'h8, 1'b1, 6'h01, 1'b0, 1'b1); tick();
        set_in(1'b0, 32'h100, 32'h8, 1'b1, 6'h02, 1'b1, 1'b0); tick();
        set_in(1'b0, 32'h100, 32'h8, 1'b1, 6'h03, 1'b1, 1'b0); tick();
        set_in(1'b0, 32'h100, 32'h8, 1'b1, 6'h04, 1'b0, 1'b1); tick();
        set_in(1'b0, 32'h100, 32'h8, 1'b1, 6'h05, 1'b1, 1'b0); tick();
        set_in(1'b0, 32'h100, 32'h8, 1'b0, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("gshare_idx",  32'(idx1), 32'h0D);
        chk("bimodal_idx", 32'(idx0), 32'h00);
        chk("stat_br",     br0,       32'd5);
        chk("stat_mis",    mis0,      32'd2);
        tick();

        // Randomized traffic against the reference model, with sparse resets.
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(0, 49) == 0),
                   {$urandom_range(0, 255), 2'b00} & 32'h3FC | (32'($urandom) & 32'hFFFF_F000),
                   $urandom,
                   $urandom_range(0, 1) == 1,
                   6'($urandom_range(0, 7) * 8 + $urandom_range(0, 1)),
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0);
            @(negedge clk);
            cmp_model("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_dyn.md
# branch_predictor_dyn

Parametrised dynamic conditional-branch predictor for the 5-stage RV32I pipeline. It is looked up in ID alongside the decoder and replaces the static backward-taken/forward-not-taken predictor there. Prediction uses a table of saturating counters indexed by PC (bimodal) or PC XOR global history (gshare). A per-entry valid bit falls back to the static sign-of-offset rule for branches the table has not yet seen. EX returns the resolved outcome to train the table. Branch and misprediction statistics are kept for the testbench.

## Interface
Parameters:
- ENTRIES, 64, pattern-table depth; power of two, ≥4; IDX_W = log2(ENTRIES)
- CTR_BITS, 2, saturating counter width, 2..4
- MODE, 0, 0 = bimodal, 1 = gshare
- HIST_BITS, 4, global history length; 1..IDX_W; ignored when MODE=0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_pc  in  32  PC of the instruction in ID
- id_imm  in  32  sign-extended branch offset from the immediate generator
- br_pred  out  1  prediction for id_pc: 1 = taken
- pred_idx  out  IDX_W  table index used for the lookup; carried down the pipe to EX
- ex_upd_en  in  1  a conditional branch in EX has resolved and was not squashed
- ex_upd_idx  in  IDX_W  pred_idx carried with that branch
- ex_taken  in  1  resolved outcome
- ex_mispred  in  1  prediction differed from the outcome
- br_cnt  out  32  resolved branches since reset
- mispred_cnt  out  32  mispredictions since reset

## Operation
- State:
  - ctr[ENTRIES], each CTR_BITS wide
  - vld[ENTRIES], 1 bit each
  - ghr, HIST_BITS wide
  - br_cnt and mispred_cnt
- Lookup (combinational):
  - MODE=0: pred_idx = id_pc[IDX_W+1:2].
  - MODE=1: pred_idx = id_pc[IDX_W+1:2] XOR {zero-extended ghr}.
  - If vld[pred_idx]=1: br_pred = MSB of ctr[pred_idx].
  - Otherwise: br_pred = id_imm[31] (static fallback).
- Update (on a clock edge where ex_upd_en=1 and rst=0):
  - Entry invalid: ctr ← 2^(CTR_BITS-1) if ex_taken, else 2^(CTR_BITS-1)-1; vld ← 1.
  - Entry valid: increment if ex_taken, decrement otherwise. Saturate at all-ones and at 0.
  - MODE=1: ghr ← {ghr[HIST_BITS-2:0], ex_taken}. For HIST_BITS=1, ghr ← ex_taken.
  - br_cnt ← br_cnt+1, saturating at 0xFFFFFFFF.
  - mispred_cnt ← mispred_cnt+1 when ex_mispred=1, saturating at 0xFFFFFFFF.
- History is non-speculative: it changes only on a resolved update. Squashed branches never assert ex_upd_en.
- The block does not decode. The IF/ID logic uses br_pred only when the ID opcode is a conditional branch.

## Timing
- Lookup has zero latency: br_pred and pred_idx are combinational from id_pc, id_imm and the registered state.
- An update becomes visible to lookups on the cycle after its edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value, with no bypass.
- Two updates never occur in one cycle; at most one branch is in EX.
- Reset (synchronous, takes effect at the edge where rst=1):
  - every ctr = 2^(CTR_BITS-1)-1 (weakly not-taken)
  - every vld = 0
  - ghr = 0
  - br_cnt = 0 and mispred_cnt = 0
- Output values while in reset: br_pred = id_imm[31], and pred_idx = id_pc[IDX_W+1:2].
- rst has priority over a simultaneous ex_upd_en; that update is discarded.
- Reset asserted mid-stream clears all state in one cycle. The first update after rst deasserts trains from the cleared state.
- Index wrap: only PC bits [IDX_W+1:2] are used, so aliasing PCs share an entry by design.

## Test plan
- Cold fallback (defaults): reset, then id_pc=0x40:
  - id_imm=0xFFFFFFF0 → br_pred=1, pred_idx=0x10
  - id_imm=0x8 → br_pred=0
- Counter training (MODE=0), applied to idx 0x10 with one update per cycle. Check after each:
  - update taken → ctr=2'b10, vld=1; lookup id_pc=0x40, id_imm=0x8 → br_pred=1
  - two more taken → ctr saturates at 2'b11
  - one not-taken → ctr=2'b10, br_pred=1
  - second not-taken → ctr=2'b01, br_pred=0
- Read-before-write: lookup and update idx 0x10 in the same cycle, entry starting at ctr=01 with ex_taken=1:
  - br_pred=0 that cycle
  - br_pred=1 the next cycle
- Gshare (MODE=1, HIST_BITS=4):
  - updates taken, taken, not, taken → ghr=4'b1101
  - lookup id_pc=0x100 → pred_idx=0x0D
- Statistics: 5 updates, 2 with ex_mispred=1 → br_cnt=5, mispred_cnt=2.
- Reset priority: assert rst together with ex_upd_en=1, ex_taken=1 on idx 0x10. Next cycle:
  - br_cnt=0, mispred_cnt=0
  - lookup id_pc=0x40, id_imm=0x8 → br_pred=0 (entry invalid)
